// File: rtl/hash_table_pkg.sv
// Shared opcodes and arbiter state encoding for the hash_table front end.
package hash_table_pkg;

  localparam logic [1:0] OP_INSERT  = 2'b00;
  localparam logic [1:0] OP_DELETE  = 2'b01;
  localparam logic [1:0] OP_SEARCH  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/hash_table_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    logic [IW-1:0] idx;
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/hash_table_arbiter.sv
// Shares one hash_table between NUM_REQ requesters: round-robin grant, one op in flight,
// watchdog timeout and illegal-opcode rejection.
module hash_table_arbiter
  import hash_table_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
  input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [VALUE_WIDTH-1:0]         resp_value,
  output logic                           resp_error,
  output logic                           resp_timeout,
  output logic                           busy,
  output logic                           ht_op_en,
  output logic [1:0]                     ht_op_sel,
  output logic [KEY_WIDTH-1:0]           ht_key_in,
  output logic [VALUE_WIDTH-1:0]         ht_value_in,
  input  logic [VALUE_WIDTH-1:0]         ht_value_out,
  input  logic                           ht_op_done,
  input  logic                           ht_op_error
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_REQ - 1);

  arb_state_e             state, next_state;
  logic [IW-1:0]          rr_ptr, id_q, grant_id;
  logic [NUM_REQ-1:0]     grant;
  logic [1:0]             op_q, sel_op;
  logic [KEY_WIDTH-1:0]   key_q, sel_key;
  logic [VALUE_WIDTH-1:0] value_q, sel_value;
  logic [CW-1:0]          cnt;
  logic                   handshake, timeout_hit;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_op      = req_op[2*int'(grant_id) +: 2];
  assign sel_key     = req_key[KEY_WIDTH*int'(grant_id) +: KEY_WIDTH];
  assign sel_value   = req_value[VALUE_WIDTH*int'(grant_id) +: VALUE_WIDTH];
  assign req_ready   = (state == IDLE) ? grant : '0;
  assign handshake   = |(req_valid & req_ready);
  assign timeout_hit = (cnt == CNT_LAST);

  assign busy        = (state != IDLE);
  assign ht_op_en    = (state == ISSUE);
  assign ht_op_sel   = op_q;
  assign ht_key_in   = key_q;
  assign ht_value_in = value_q;
  assign resp_valid  = (state == RESP) ? (NUM_REQ'(1) << id_q) : '0;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = (sel_op == OP_ILLEGAL) ? RESP : ISSUE;
      ISSUE:   next_state = WAIT;
      // A completion in the expiring cycle still counts as a normal completion.
      WAIT:    if (ht_op_done || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      op_q         <= '0;
      key_q        <= '0;
      value_q      <= '0;
      cnt          <= '0;
      resp_value   <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (handshake) begin
            id_q    <= grant_id;
            op_q    <= sel_op;
            key_q   <= sel_key;
            value_q <= sel_value;
            rr_ptr  <= (grant_id == ID_LAST) ? '0 : grant_id + IW'(1);
            if (sel_op == OP_ILLEGAL) begin
              resp_value   <= '0;
              resp_error   <= 1'b1;
              resp_timeout <= 1'b0;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (ht_op_done) begin
            resp_value   <= ht_value_out;
            resp_error   <= ht_op_error;
            resp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            resp_value   <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Directed bench for hash_table_arbiter with a behavioural hash_table responder.
module tb_hash_table_arbiter;
  import hash_table_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int KW      = 32;
  localparam int VW      = 32;
  localparam int TO      = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready, resp_valid;
  logic [2*NUM_REQ-1:0]  req_op = '0;
  logic [KW*NUM_REQ-1:0] req_key = '0;
  logic [VW*NUM_REQ-1:0] req_value = '0;
  logic [VW-1:0]         resp_value, ht_value_in;
  logic                  resp_error, resp_timeout, busy, ht_op_en;
  logic [1:0]            ht_op_sel;
  logic [KW-1:0]         ht_key_in;
  logic [VW-1:0]         ht_value_out = '0;
  logic                  ht_op_done, ht_op_error = 1'b0;

  logic          model_done = 1'b0;
  logic          stray_done = 1'b0;
  logic          model_respond = 1'b1;
  int            model_delay = 1;
  logic [VW-1:0] model_value = '0;
  logic          model_error = 1'b0;
  int            pend = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            id;
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic          respond;
    int            delay;
    logic [VW-1:0] mvalue;
    logic          merror;
    int            exp_lat;
    logic [VW-1:0] exp_value;
    logic          check_value;
    logic          exp_error;
    logic          exp_timeout;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  assign ht_op_done = model_done | stray_done;

  hash_table_arbiter #(
    .NUM_REQ(NUM_REQ), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_value(resp_value), .resp_error(resp_error),
    .resp_timeout(resp_timeout), .busy(busy),
    .ht_op_en(ht_op_en), .ht_op_sel(ht_op_sel), .ht_key_in(ht_key_in),
    .ht_value_in(ht_value_in), .ht_value_out(ht_value_out),
    .ht_op_done(ht_op_done), .ht_op_error(ht_op_error)
  );

  // Table model: done pulses model_delay cycles after the op_en cycle.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        model_done   = 1'b1;
        ht_value_out = model_value;
        ht_op_error  = model_error;
      end
    end
    if (ht_op_en && model_respond) pend = model_delay;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req_ready"}, req_ready, 0);
    checkOutput({tag, " resp_valid"}, resp_valid, 0);
    checkOutput({tag, " resp_value"}, resp_value, 0);
    checkOutput({tag, " resp_error"}, resp_error, 0);
    checkOutput({tag, " resp_timeout"}, resp_timeout, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " ht_op_en"}, ht_op_en, 0);
    checkOutput({tag, " ht_op_sel"}, ht_op_sel, 0);
    checkOutput({tag, " ht_key_in"}, ht_key_in, 0);
    checkOutput({tag, " ht_value_in"}, ht_value_in, 0);
  endtask

  task automatic setRequester(input int id, input logic [1:0] op, input logic [KW-1:0] key,
                              input logic [VW-1:0] value);
    req_op[2*id +: 2]      = op;
    req_key[KW*id +: KW]   = key;
    req_value[VW*id +: VW] = value;
  endtask

  // One complete transaction from a single requester; latency counted from the handshake cycle.
  task automatic applyStimulus(input int vi, input vec_t v);
    int n, op_en_seen, busy_cycles;
    bit got;
    @(negedge clk);
    model_respond = v.respond;
    model_delay   = v.delay;
    model_value   = v.mvalue;
    model_error   = v.merror;
    setRequester(v.id, v.op, v.key, v.value);
    req_valid = NUM_REQ'(1) << v.id;
    #1;
    checkOutput($sformatf("v%0d grant", vi), req_ready, 64'(1) << v.id);
    got = 0; n = 0; op_en_seen = 0; busy_cycles = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      n++;
      if (busy) busy_cycles++;
      if (ht_op_en) begin
        op_en_seen++;
        checkOutput($sformatf("v%0d op_en cycle", vi), n, 1);
        checkOutput($sformatf("v%0d ht_op_sel", vi), ht_op_sel, v.op);
        checkOutput($sformatf("v%0d ht_key_in", vi), ht_key_in, v.key);
        checkOutput($sformatf("v%0d ht_value_in", vi), ht_value_in, v.value);
      end
      if (resp_valid != 0) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL v%0d response wait: got none in %0d cycles, expected one", vi, n);
    end
    checkOutput($sformatf("v%0d latency", vi), n, v.exp_lat);
    checkOutput($sformatf("v%0d resp_valid", vi), resp_valid, 64'(1) << v.id);
    checkOutput($sformatf("v%0d resp_error", vi), resp_error, v.exp_error);
    checkOutput($sformatf("v%0d resp_timeout", vi), resp_timeout, v.exp_timeout);
    if (v.check_value) checkOutput($sformatf("v%0d resp_value", vi), resp_value, v.exp_value);
    checkOutput($sformatf("v%0d op_en count", vi), op_en_seen, (v.op == OP_ILLEGAL) ? 0 : 1);
    checkOutput($sformatf("v%0d busy cycles", vi), busy_cycles, v.exp_lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int grants, resps, last_grant, cyc, n;
    bit got;

    // Latency = 2 + model delay; watchdog fires after TO WAIT cycles (latency 2 + TO).
    vecs[0] = '{0, OP_INSERT, 32'h10, 32'hAB,   1'b1, 1,  32'h0,    1'b0, 3,  32'h0,    1'b1, 1'b0, 1'b0};
    vecs[1] = '{2, OP_SEARCH, 32'h22, 32'h0,    1'b1, 6,  32'hDEAD, 1'b0, 8,  32'hDEAD, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1, OP_INSERT, 32'h33, 32'h99,   1'b1, 2,  32'h1234, 1'b1, 4,  32'h1234, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1, OP_DELETE, 32'h44, 32'h0,    1'b0, 1,  32'h0,    1'b0, 66, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[4] = '{0, OP_SEARCH, 32'h55, 32'h0,    1'b1, 64, 32'hBEEF, 1'b0, 66, 32'hBEEF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2, OP_SEARCH, 32'h66, 32'h0,    1'b1, 65, 32'hCAFE, 1'b0, 66, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[6] = '{3, OP_ILLEGAL, 32'h77, 32'h5,   1'b1, 1,  32'h0,    1'b0, 1,  32'h0,    1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    // A stray completion while idle must not produce a response.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stray resp_valid %0d", i), resp_valid, 0);
      checkOutput($sformatf("stray busy %0d", i), busy, 0);
      @(negedge clk);
    end

    // The illegal op from requester 3 left rr_ptr at 0, so all-valid grants run 0,1,2,3,0.
    model_respond = 1'b1; model_delay = 1; model_value = 32'h77; model_error = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) setRequester(i, OP_SEARCH, KW'(32'h100 + i), VW'(i));
    grants = 0; resps = 0; last_grant = 0; cyc = 0;
    while ((grants < 5 || resps < 5) && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      req_valid = (grants < 5) ? '1 : '0;
      #1;
      cyc++;
      checkOutput("rot ready onehot", $countones(req_ready) <= 1, 1);
      if (req_ready != 0) begin
        checkOutput($sformatf("rot grant %0d", grants), req_ready, 64'(1) << (grants % NUM_REQ));
        last_grant = grants % NUM_REQ;
        grants++;
      end
      if (ht_op_en) checkOutput("rot ht_key_in", ht_key_in, 32'h100 + last_grant);
      if (resp_valid != 0) begin
        checkOutput($sformatf("rot resp owner %0d", resps), resp_valid, 64'(1) << last_grant);
        checkOutput($sformatf("rot resp_value %0d", resps), resp_value, 32'h77);
        resps++;
      end
    end
    checkOutput("rot grants", grants, 5);
    checkOutput("rot responses", resps, 5);

    // Reset during WAIT abandons the op; rr_ptr was 2, reset returns it to 0.
    @(negedge clk);
    req_valid = '0;
    model_respond = 1'b0;
    setRequester(1, OP_DELETE, 32'h88, 32'h5A);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checkOutput("rst-op grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("rst-op op_en", ht_op_en, 1);
    @(negedge clk);
    #1;
    checkOutput("rst-op waiting", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkResetState("mid-op reset");
    @(negedge clk);
    rst = 1'b1;
    model_respond = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("post-reset resp_valid %0d", i), resp_valid, 0);
      checkOutput($sformatf("post-reset op_en %0d", i), ht_op_en, 0);
      @(negedge clk);
    end
    req_valid = '1;
    #1;
    checkOutput("post-reset first grant", req_ready, 4'b0001);
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      n++;
      if (resp_valid != 0) got = 1;
    end
    checkOutput("post-reset resp_valid", resp_valid, 4'b0001);
    checkOutput("post-reset latency", n, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
